// File: rtl/scc_wave_gen_if.sv
// Register bus between a host and scc_wave_gen: request/write strobe, offset,
// write data, one-cycle acknowledge and read data.
interface scc_wave_gen_if;
    logic       req;
    logic       wrt;
    logic [7:0] adr;
    logic [7:0] dbo;
    logic       ack;
    logic [7:0] dbi;

    modport master (output req, wrt, adr, dbo, input ack, dbi);
    modport slave  (input req, wrt, adr, dbo, output ack, dbi);
endinterface

// File: rtl/scc_wave_gen.sv
// SCC / SCC+ wavetable sound generator with a sequential one-channel-per-clock mixer.
// Define SCC_WAVE_READBACK_EN to return wave RAM bytes on read acknowledges.
module scc_wave_gen #(
    parameter int CHANNELS = 5,
    parameter int OUT_W    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clkena,
    scc_wave_gen_if.slave           bus,
    input  logic                    sccPlusChip,
    input  logic                    sccPlusMode,
    output logic signed [OUT_W-1:0] wave
);
    typedef enum logic [1:0] {S_IDLE, S_MIX, S_DONE} state_t;

    localparam logic [2:0] LAST = 3'(CHANNELS - 1);

    logic       plus;
    logic       ram_hit;
    logic       reg_hit;
    logic       wr_stb;
    logic [3:0] rel;

    logic [7:0]  ram [0:159];
    logic [4:0]  mask;
    logic [11:0] freq [5];
    logic [3:0]  vol  [5];
    logic [4:0]  ptr  [5];

    assign plus    = sccPlusChip & sccPlusMode;
    assign ram_hit = plus ? (bus.adr < 8'hA0) : ~bus.adr[7];
    assign reg_hit = plus ? (bus.adr[7:4] == 4'hA) : (bus.adr[7:4] == 4'h8);
    assign rel     = bus.adr[3:0];
    assign wr_stb  = bus.req & bus.wrt & ~reset;

    // Wave RAM is never reset; the mixer reads it asynchronously and so sees
    // the pre-write value when a write lands on the same address.
    always_ff @(posedge clk) begin
        if (wr_stb && ram_hit)
            ram[bus.adr] <= bus.dbo;
    end

    always_ff @(posedge clk) begin
        if (reset)
            mask <= '0;
        else if (wr_stb && reg_hit && rel == 4'hF)
            mask <= bus.dbo[4:0];
    end

    for (genvar c = 0; c < 5; c++) begin : g_ch
        logic        fwr;
        logic        vwr;
        logic [11:0] fnew;
        logic [11:0] freq_q;
        logic [3:0]  vol_q;

        assign fwr  = wr_stb && reg_hit && rel < 4'hA && rel[3:1] == 3'(c);
        assign vwr  = wr_stb && reg_hit && rel == 4'(10 + c);
        assign fnew = rel[0] ? {bus.dbo[3:0], freq_q[7:0]} : {freq_q[11:8], bus.dbo};

        always_ff @(posedge clk) begin
            if (reset) begin
                freq_q <= '0;
                vol_q  <= '0;
            end else begin
                if (fwr) freq_q <= fnew;
                if (vwr) vol_q  <= bus.dbo[3:0];
            end
        end

        assign freq[c] = freq_q;
        assign vol[c]  = vol_q;

        if (c < CHANNELS) begin : g_on
            logic [11:0] cnt_q;
            logic [4:0]  ptr_q;

            // A frequency write reloads the counter and beats a same-edge tick.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    ptr_q <= '0;
                end else if (fwr) begin
                    cnt_q <= fnew;
                end else if (clkena && freq_q >= 12'd9) begin
                    if (cnt_q == 12'd0) begin
                        cnt_q <= freq_q;
                        ptr_q <= ptr_q + 5'd1;
                    end else begin
                        cnt_q <= cnt_q - 12'd1;
                    end
                end
            end

            assign ptr[c] = ptr_q;
        end else begin : g_off
            assign ptr[c] = '0;
        end
    end

    state_t                  state, state_n;
    logic [2:0]              idx, idx_n;
    logic signed [OUT_W-1:0] acc, acc_n;
    logic                    wave_ld;
    logic [2:0]              bank;
    logic [7:0]              maddr;
    logic signed [12:0]      smp13, vol13, prod;
    logic signed [OUT_W-1:0] term;

    // In the plain SCC map channel 4 shares bank 3 with channel 3.
    assign bank  = (idx == 3'd4 && !plus) ? 3'd3 : idx;
    assign maddr = {bank, ptr[idx]};
    assign smp13 = 13'($signed(ram[maddr]));
    assign vol13 = {9'd0, vol[idx]};
    assign prod  = smp13 * vol13;
    assign term  = mask[idx] ? OUT_W'(prod) : '0;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        acc_n   = acc;
        wave_ld = 1'b0;
        case (state)
            S_MIX: begin
                acc_n = acc + term;
                if (idx == LAST) begin
                    idx_n   = '0;
                    state_n = S_DONE;
                end else begin
                    idx_n = idx + 3'd1;
                end
            end
            S_DONE: begin
                wave_ld = 1'b1;
                state_n = S_IDLE;
            end
            default: ;
        endcase
        // A tick always (re)starts the sweep; any partial sum is dropped.
        if (clkena) begin
            state_n = S_MIX;
            idx_n   = '0;
            acc_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            acc   <= '0;
            wave  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            acc   <= acc_n;
            if (wave_ld) wave <= acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) bus.ack <= 1'b0;
        else       bus.ack <= bus.req;
    end

`ifdef SCC_WAVE_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset)
            bus.dbi <= 8'hFF;
        else if (bus.req && !bus.wrt && ram_hit)
            bus.dbi <= ram[bus.adr];
        else
            bus.dbi <= 8'hFF;
    end
`else
    assign bus.dbi = 8'hFF;
`endif
endmodule

// File: tb/tb_scc_wave_gen.sv
// Scoreboard bench for scc_wave_gen: stimulus pushes expected acks/dbi and wave
// samples, a negedge monitor pops and compares as the DUT produces them.
module tb_scc_wave_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clkena = 1'b0;
    logic sccPlusChip = 1'b1;
    logic sccPlusMode = 1'b0;
    logic signed [14:0] wave;

    scc_wave_gen_if bus ();

    scc_wave_gen #(.CHANNELS(5), .OUT_W(15)) dut (
        .clk(clk),
        .reset(reset),
        .clkena(clkena),
        .bus(bus),
        .sccPlusChip(sccPlusChip),
        .sccPlusMode(sccPlusMode),
        .wave(wave)
    );

    always #5 clk = ~clk;

`ifdef SCC_WAVE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] dq[$];
    int wq[$];
    logic [6:0] tk = '0;
    logic rst_hit = 1'b1;
    logic ack_exp = 1'b0;
    int last_wave = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Tick age tracker: a tick seen while a sweep is in flight kills the older one.
    always @(posedge clk) begin
        ack_exp <= bus.req & ~reset;
        if (reset) begin
            tk      <= '0;
            rst_hit <= 1'b1;
        end else begin
            tk      <= {tk[5], tk[4:0] & {5{~clkena}}, clkena};
            rst_hit <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_hit) last_wave = 0;
            if (tk[6]) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wave_unexpected_update actual=%0d", int'(wave));
                end else begin
                    last_wave = wq.pop_front();
                end
            end
            chk("wave", int'(wave), last_wave);
            chk("ack", int'(bus.ack), int'(ack_exp));
            if (bus.ack) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected actual=1 expected=0");
                end else begin
                    chk("dbi_ack", int'(bus.dbi), int'(dq.pop_front()));
                end
            end else begin
                chk("dbi_idle", int'(bus.dbi), 255);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.req = 1'b1; bus.wrt = 1'b1; bus.adr = a; bus.dbo = d;
        dq.push_back(8'hFF);
        cyc();
        bus.req = 1'b0; bus.wrt = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        bus.req = 1'b1; bus.wrt = 1'b0; bus.adr = a;
        dq.push_back(exp);
        cyc();
        bus.req = 1'b0;
    endtask

    task automatic tick(input int expv);
        clkena = 1'b1;
        wq.push_back(expv);
        cyc();
        clkena = 1'b0;
        repeat (7) cyc();
    endtask

    initial begin
        bus.req = 1'b0; bus.wrt = 1'b0; bus.adr = '0; bus.dbo = '0;
        cyc();
        mon_en = 1'b1;
        cyc(); cyc();
        reset = 1'b0;

        // Mask write, single ack
        wr(8'h8F, 8'h01);
        cyc();
        chk("mask_after_write", int'(dut.mask), 1);

        // ch0: 7F then 01, full volume, freq 9 -> pointer steps every 10 ticks
        wr(8'h00, 8'h7F); wr(8'h01, 8'h01); wr(8'h8A, 8'h0F);
        wr(8'h80, 8'h09); wr(8'h81, 8'h00);
        chk("cnt0_load9", int'(dut.g_ch[0].g_on.cnt_q), 9);
        for (int k = 1; k <= 12; k++) begin
            tick(k <= 9 ? 1905 : 15);
            if (k == 9)  chk("ptr0_tick9", int'(dut.ptr[0]), 0);
            if (k == 10) chk("ptr0_tick10", int'(dut.ptr[0]), 1);
        end

        // freq 8 freezes the channel
        wr(8'h80, 8'h08);
        chk("cnt0_load8", int'(dut.g_ch[0].g_on.cnt_q), 8);
        repeat (100) tick(15);
        chk("ptr0_frozen", int'(dut.ptr[0]), 1);

        // All channels at -128 x 15 in SCC+ map
        sccPlusMode = 1'b1;
        for (int a = 0; a < 160; a++) wr(8'(a), 8'h80);
        for (int c = 0; c < 5; c++) wr(8'(8'hAA + c), 8'h0F);
        wr(8'hAF, 8'h1F);
        tick(-9600);
        // bank3[0] = 0x40: SCC map routes ch4 to bank 3
        sccPlusMode = 1'b0;
        wr(8'h60, 8'h40);
        tick(-3840);
        sccPlusMode = 1'b1;
        tick(-6720);

        // Readback
        wr(8'h05, 8'hA5);
        rd(8'h05, RB ? 8'hA5 : 8'hFF);
        rd(8'h85, RB ? 8'h80 : 8'hFF);
        sccPlusMode = 1'b0;
        rd(8'h85, 8'hFF);
        rd(8'h90, 8'hFF);
        sccPlusChip = 1'b0; sccPlusMode = 1'b1;
        rd(8'h85, 8'hFF);
        sccPlusChip = 1'b1;
        cyc();

        // Restart: second tick 3 clk after the first; ch0 muted in between
        clkena = 1'b1; cyc(); clkena = 1'b0;
        cyc();
        bus.req = 1'b1; bus.wrt = 1'b1; bus.adr = 8'hAA; bus.dbo = 8'h00;
        dq.push_back(8'hFF);
        cyc();
        bus.req = 1'b0; bus.wrt = 1'b0;
        clkena = 1'b1; wq.push_back(-4800);
        cyc();
        clkena = 1'b0;
        repeat (10) cyc();

        // Reset mid-mix, coinciding with req and clkena
        clkena = 1'b1; cyc(); clkena = 1'b0;
        cyc();
        reset = 1'b1; clkena = 1'b1;
        bus.req = 1'b1; bus.wrt = 1'b1; bus.adr = 8'hAF; bus.dbo = 8'h1F;
        cyc();
        reset = 1'b0; clkena = 1'b0; bus.req = 1'b0; bus.wrt = 1'b0;
        repeat (10) cyc();
        chk("mask_after_reset", int'(dut.mask), 0);
        chk("cnt0_reset", int'(dut.g_ch[0].g_on.cnt_q), 0);
        chk("cnt1_reset", int'(dut.g_ch[1].g_on.cnt_q), 0);
        chk("cnt2_reset", int'(dut.g_ch[2].g_on.cnt_q), 0);
        chk("cnt3_reset", int'(dut.g_ch[3].g_on.cnt_q), 0);
        chk("cnt4_reset", int'(dut.g_ch[4].g_on.cnt_q), 0);
        chk("ptr0_reset", int'(dut.ptr[0]), 0);

        chk("wave_queue_drained", wq.size(), 0);
        chk("ack_queue_drained", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
